// File: rtl/mano_io_interface.sv
// mano_io_interface: INPR/OUTR I/O stage for the Mano-machine control unit.
// Input side loads INPR from a valid/ready source and raises FGI with a
// one-cycle input_read pulse. Output side is a two-state FSM that loads
// OUTR from AC on OUTER_LD and drains it to a valid/ready sink.
// Build option: define IO_RX_FIFO_EN to place a FIFO_DEPTH-entry receive
// FIFO ahead of INPR; otherwise rx bytes go straight into INPR.
module mano_io_interface #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] AC_IN,
  input  logic              OUTER_LD,
  input  logic              INP_ACK,
  output logic [DATA_W-1:0] INPR,
  output logic              FGI,
  output logic              FGO,
  output logic              input_read,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              out_overrun
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } out_state_t;

  out_state_t        state, state_nxt;
  logic [DATA_W-1:0] outr;
  logic              overrun;
  logic [DATA_W-1:0] inpr_q;
  logic              fgi_q;
  logic              ir_q;

`ifdef IO_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = FIFO_DEPTH[PTR_W:0];

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, push, pop;

  assign full     = (count == DEPTH_CNT);
  assign rx_ready = !full;
  assign push     = rx_valid && !full;
  // The head moves into INPR whenever INPR has been consumed (FGI low).
  assign pop      = !fgi_q && (count != '0);

  // FIFO storage; contents need no reset since count defines occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // INPR/FGI/input_read loaded from the FIFO head; a pop implies FGI=0,
  // so it can never collide with an INP_ACK that matters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
      ir_q   <= 1'b0;
    end else begin
      ir_q <= 1'b0;
      if (pop) begin
        inpr_q <= mem[rd_ptr];
        fgi_q  <= 1'b1;
        ir_q   <= 1'b1;
      end else if (INP_ACK) begin
        fgi_q <= 1'b0;
      end
    end
  end
`else
  logic accept;

  assign rx_ready = !fgi_q;
  assign accept   = rx_valid && !fgi_q;

  // INPR/FGI/input_read loaded directly from the rx source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inpr_q <= '0;
      fgi_q  <= 1'b0;
      ir_q   <= 1'b0;
    end else begin
      ir_q <= 1'b0;
      if (accept) begin
        inpr_q <= rx_data;
        fgi_q  <= 1'b1;
        ir_q   <= 1'b1;
      end else if (INP_ACK) begin
        fgi_q <= 1'b0;
      end
    end
  end
`endif

  assign INPR       = inpr_q;
  assign FGI        = fgi_q;
  assign input_read = ir_q;

  // Output FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Output FSM next-state: load on OUTER_LD, finish on sink handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (OUTER_LD) state_nxt = ST_SEND;
      ST_SEND: if (tx_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // OUTR capture in IDLE; any OUTER_LD seen in SEND (including the
  // handshake cycle) is dropped and latched as a sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outr    <= '0;
      overrun <= 1'b0;
    end else begin
      if (OUTER_LD && (state == ST_IDLE)) outr    <= AC_IN;
      if (OUTER_LD && (state == ST_SEND)) overrun <= 1'b1;
    end
  end

  assign FGO         = (state == ST_IDLE);
  assign tx_valid    = (state == ST_SEND);
  assign tx_data     = outr;
  assign out_overrun = overrun;

endmodule

// File: tb/tb_mano_io_interface.sv
// Self-checking bench for mano_io_interface: directed plan scenarios plus
// randomized traffic compared against a behavioural model.
module tb_mano_io_interface;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk, rst;
  logic [DW-1:0] rx_data, AC_IN, INPR, tx_data;
  logic          rx_valid, rx_ready, OUTER_LD, INP_ACK;
  logic          FGI, FGO, input_read, tx_valid, tx_ready, out_overrun;

  mano_io_interface #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .AC_IN(AC_IN), .OUTER_LD(OUTER_LD), .INP_ACK(INP_ACK),
    .INPR(INPR), .FGI(FGI), .FGO(FGO), .input_read(input_read),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .out_overrun(out_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] m_inpr, m_outr;
  bit            m_fgi, m_ir, m_busy, m_ovr;
  logic [DW-1:0] m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inpr = '0; m_outr = '0;
    m_fgi = 0; m_ir = 0; m_busy = 0; m_ovr = 0;
    m_q.delete();
  endtask

  function automatic bit model_rx_ready();
`ifdef IO_RX_FIFO_EN
    return m_q.size() < DEPTH;
`else
    return !m_fgi;
`endif
  endfunction

  task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit ack,
                            input bit ld, input logic [DW-1:0] ac, input bit tr);
    bit was_busy;
`ifdef IO_RX_FIFO_EN
    bit do_push, do_pop;
    do_push = v && (m_q.size() < DEPTH);
    do_pop  = !m_fgi && (m_q.size() > 0);
    m_ir = 0;
    if (m_fgi && ack) m_fgi = 0;
    if (do_pop) begin
      m_inpr = m_q.pop_front();
      m_fgi  = 1;
      m_ir   = 1;
    end
    if (do_push) m_q.push_back(d);
`else
    m_ir = 0;
    if (!m_fgi && v) begin
      m_inpr = d; m_fgi = 1; m_ir = 1;
    end else if (m_fgi && ack) begin
      m_fgi = 0;
    end
`endif
    was_busy = m_busy;
    if (!was_busy) begin
      if (ld) begin m_outr = ac; m_busy = 1; end
    end else begin
      if (ld) m_ovr = 1;
      if (tr) m_busy = 0;
    end
  endtask

  task automatic check_outputs();
    check("INPR", INPR, m_inpr);
    check("FGI", FGI, m_fgi);
    check("input_read", input_read, m_ir);
    check("tx_data", tx_data, m_outr);
    check("tx_valid", tx_valid, m_busy);
    check("FGO", FGO, !m_busy);
    check("out_overrun", out_overrun, m_ovr);
  endtask

  // Drive one cycle of inputs, check rx_ready before the edge, outputs after.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit ack,
                      input bit ld, input logic [DW-1:0] ac, input bit tr);
    rx_valid = v; rx_data = d; INP_ACK = ack;
    OUTER_LD = ld; AC_IN = ac; tx_ready = tr;
    #1;
    check("rx_ready", rx_ready, model_rx_ready());
    @(posedge clk);
    model_edge(v, d, ack, ld, ac, tr);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must change before any edge.
  task automatic do_reset();
    rx_valid = 0; INP_ACK = 0; OUTER_LD = 0; tx_ready = 0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_INPR", INPR, 0);
    check("rst_FGI", FGI, 0);
    check("rst_FGO", FGO, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overrun", out_overrun, 0);
    check("rst_input_read", input_read, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rx_valid = 0; rx_data = '0; INP_ACK = 0;
    OUTER_LD = 0; AC_IN = '0; tx_ready = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Scenario: some traffic then a mid-cycle reset drops everything.
    step(1, 8'h77, 0, 1, 8'h99, 0);
    step(0, 8'h00, 0, 1, 8'h11, 0);
    do_reset();

    // Input handshake and FGI gating.
    step(1, 8'h41, 0, 0, 8'h00, 0);
`ifndef IO_RX_FIFO_EN
    check("t2_inpr", INPR, 8'h41);
    check("t2_fgi", FGI, 1);
    check("t2_ir", input_read, 1);
    check("t2_rx_ready", rx_ready, 0);
`endif
    step(1, 8'h42, 0, 0, 8'h00, 0);
`ifndef IO_RX_FIFO_EN
    check("t2_hold_inpr", INPR, 8'h41);
    check("t2_ir_once", input_read, 0);
`endif
    step(1, 8'h42, 1, 0, 8'h00, 0);
`ifndef IO_RX_FIFO_EN
    check("t2_ack_fgi", FGI, 0);
`endif
    step(1, 8'h42, 0, 0, 8'h00, 0);
`ifndef IO_RX_FIFO_EN
    check("t2_next_inpr", INPR, 8'h42);
`endif
    step(0, 8'h00, 1, 0, 8'h00, 0);
    step(0, 8'h00, 1, 0, 8'h00, 0);

    // Output drain with a stalled sink and an overrun load.
    step(0, 8'h00, 0, 1, 8'h5A, 0);
    check("t3_tx_data", tx_data, 8'h5A);
    check("t3_fgo", FGO, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0);
    step(0, 8'h00, 0, 1, 8'h33, 0);
    check("t4_tx_data", tx_data, 8'h5A);
    check("t4_overrun", out_overrun, 1);
    step(0, 8'h00, 0, 0, 8'h00, 0);
    check("t3_still_valid", tx_valid, 1);
    step(0, 8'h00, 0, 0, 8'h00, 1);
    check("t3_fgo_done", FGO, 1);
    check("t3_valid_done", tx_valid, 0);
    check("t4_sticky", out_overrun, 1);

    // Simultaneous rx accept and OUTR load.
    step(1, 8'h10, 0, 1, 8'h20, 0);
`ifndef IO_RX_FIFO_EN
    check("t5_inpr", INPR, 8'h10);
    check("t5_fgi", FGI, 1);
`endif
    check("t5_tx_data", tx_data, 8'h20);
    check("t5_fgo", FGO, 0);
    step(0, 8'h00, 1, 0, 8'h00, 1);
    step(0, 8'h00, 1, 0, 8'h00, 0);

`ifdef IO_RX_FIFO_EN
    // FIFO fill and drain.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0, 8'h00, 0);
    check("t6_inpr", INPR, 8'h01);
    check("t6_full", rx_ready, 0);
    for (int i = 2; i <= 4; i++) begin
      step(0, 8'h00, 1, 0, 8'h00, 0);
      step(0, 8'h00, 0, 0, 8'h00, 0);
      check("t6_step_inpr", INPR, i);
      check("t6_step_ir", input_read, 1);
      check("t6_ready", rx_ready, 1);
    end
`endif

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 3) == 0,
             $urandom_range(0, 6) == 0, 8'($urandom), $urandom_range(0, 4) < 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
